// File: rtl/rb_dp.sv
// Dual-port register bank with registered read and a clear-sweep sequencer.
// Define RB_DP_BYPASS_EN for new-data on same-address read-during-write.
module rb_dp #(
    parameter int unsigned WORD_WIDTH = 18,
    parameter int unsigned WORD_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  WENn,
    input  logic [ADDR_WIDTH-1:0] WA,
    input  logic [WORD_WIDTH-1:0] D,
    input  logic                  RENn,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic                  CLR,
    output logic [WORD_WIDTH-1:0] Q,
    output logic                  QV,
    output logic                  BUSY
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(WORD_DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] q_q, q_d;
    logic                  qv_q, qv_d;

    logic [WORD_WIDTH-1:0] mem_q [WORD_DEPTH];

    logic                  wa_ok, ra_ok, rd_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [WORD_WIDTH-1:0] mem_wd;
    logic [WORD_WIDTH-1:0] rd_data;

    assign wa_ok = {1'b0, WA} < DEPTH_C;
    assign ra_ok = {1'b0, RA} < DEPTH_C;
    assign rd_en = !RENn && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (CLR) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sweep owns the write port; user writes are dropped while it runs.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = WA;
        mem_wd = D;
        if (state_q == SWEEP) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
        end else if (!WENn && wa_ok) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        rd_data = ra_ok ? mem_q[RA] : '0;
`ifdef RB_DP_BYPASS_EN
        if (ra_ok && !WENn && (WA == RA)) begin
            rd_data = D;
        end
`endif
        q_d  = rd_en ? rd_data : q_q;
        qv_d = rd_en;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
        end
    end

    // Array has no reset; RSTn gating keeps writes out while reset is held.
    always_ff @(posedge CLK) begin
        if (mem_we && RSTn) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign Q    = q_q;
    assign QV   = qv_q;
    assign BUSY = (state_q == SWEEP);

endmodule

// File: tb/tb_rb_dp.sv
// Scoreboard bench for rb_dp: default instance (depth 8) and a depth-6 instance.
module tb_rb_dp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen_n, ren_n, clr;
    logic [2:0]  wa, ra;
    logic [17:0] d;
    logic [17:0] q;
    logic        qv, busy;

    logic        wen6_n, ren6_n, clr6;
    logic [2:0]  wa6, ra6;
    logic [17:0] d6;
    logic [17:0] q6;
    logic        qv6, busy6;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [17:0] exp8[$];
    logic [17:0] exp6[$];

    always #5 clk = ~clk;

    rb_dp dut (
        .CLK (clk), .RSTn(rst_n), .WENn(wen_n), .WA(wa), .D(d),
        .RENn(ren_n), .RA(ra), .CLR(clr), .Q(q), .QV(qv), .BUSY(busy)
    );

    rb_dp #(.WORD_WIDTH(18), .WORD_DEPTH(6), .ADDR_WIDTH(3)) dut6 (
        .CLK (clk), .RSTn(rst_n), .WENn(wen6_n), .WA(wa6), .D(d6),
        .RENn(ren6_n), .RA(ra6), .CLR(clr6), .Q(q6), .QV(qv6), .BUSY(busy6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon8();
        forever begin
            @(negedge clk);
            if (qv === 1'b1) begin
                if (exp8.size() == 0) chk("qv_unexpected_dut8", 32'(qv), 32'd0);
                else chk("q_dut8", 32'(q), 32'(exp8.pop_front()));
            end
        end
    endtask

    task automatic mon6();
        forever begin
            @(negedge clk);
            if (qv6 === 1'b1) begin
                if (exp6.size() == 0) chk("qv_unexpected_dut6", 32'(qv6), 32'd0);
                else chk("q_dut6", 32'(q6), 32'(exp6.pop_front()));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wn, input logic [2:0] aw, input logic [17:0] dd,
                         input logic rn, input logic [2:0] ar, input logic c);
        wen_n = wn; wa = aw; d = dd; ren_n = rn; ra = ar; clr = c;
    endtask

    task automatic drive_idle();
        drive(1'b1, 3'd0, 18'h0, 1'b1, 3'd0, 1'b0);
    endtask

    task automatic op(input logic wn, input logic [2:0] aw, input logic [17:0] dd,
                      input logic rn, input logic [2:0] ar, input logic c);
        drive(wn, aw, dd, rn, ar, c);
        step();
        drive_idle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [17:0] dd);
        op(1'b0, a, dd, 1'b1, 3'd0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [17:0] e);
        exp8.push_back(e);
        op(1'b1, 3'd0, 18'h0, 1'b0, a, 1'b0);
    endtask

    task automatic op6(input logic wn, input logic [2:0] aw, input logic [17:0] dd,
                       input logic rn, input logic [2:0] ar);
        wen6_n = wn; wa6 = aw; d6 = dd; ren6_n = rn; ra6 = ar;
        step();
        wen6_n = 1'b1; ren6_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive_idle();
        wen6_n = 1'b1; ren6_n = 1'b1; clr6 = 1'b0; wa6 = '0; ra6 = '0; d6 = '0;
        fork
            mon8();
            mon6();
        join_none

        #2;
        chk("reset_q",     32'(q),     32'd0);
        chk("reset_qv",    32'(qv),    32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_q6",    32'(q6),    32'd0);
        chk("reset_busy6", 32'(busy6), 32'd0);
        #20 rst_n = 1'b1;
        step();

        // Depth-6 instance: out-of-range write ignored, out-of-range read gives 0.
        for (int i = 0; i < 6; i++) op6(1'b0, 3'(i), 18'h06000 + 18'(i), 1'b1, 3'd0);
        op6(1'b0, 3'd7, 18'h12345, 1'b1, 3'd0);
        exp6.push_back(18'h0);
        op6(1'b1, 3'd0, 18'h0, 1'b0, 3'd7);
        for (int i = 0; i < 6; i++) begin
            exp6.push_back(18'h06000 + 18'(i));
            op6(1'b1, 3'd0, 18'h0, 1'b0, 3'(i));
        end

        // Basic write/read, QV single-cycle, Q held afterwards.
        wr(3'd5, 18'h3FFFF);
        rd(3'd5, 18'h3FFFF);
        step();
        chk("qv_drops", 32'(qv), 32'd0);
        chk("q_held",   32'(q),  32'h3FFFF);

        // Same-address read during write.
        wr(3'd2, 18'h00011);
`ifdef RB_DP_BYPASS_EN
        exp8.push_back(18'h00022);
`else
        exp8.push_back(18'h00011);
`endif
        op(1'b0, 3'd2, 18'h00022, 1'b0, 3'd2, 1'b0);
        rd(3'd2, 18'h00022);

        // Independent ports every cycle.
        wr(3'd4, 18'h0AB4C);
        for (int i = 0; i < 8; i++) begin
            exp8.push_back(18'h0AB4C);
            op(1'b0, 3'd1, 18'h00100 + 18'(i), 1'b0, 3'd4, 1'b0);
        end
        rd(3'd1, 18'h00107);

        // Full clear sweep with dropped requests and an ignored re-CLR.
        for (int i = 0; i < 8; i++) wr(3'(i), 18'h01000 + 18'(i));
        op(1'b1, 3'd0, 18'h0, 1'b1, 3'd0, 1'b1);
        chk("busy_sweep_0", 32'(busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            if (k == 2) drive(1'b1, 3'd0, 18'h0, 1'b0, 3'd3, 1'b0);
            if (k == 3) drive(1'b1, 3'd0, 18'h0, 1'b1, 3'd0, 1'b1);
            if (k == 6) drive(1'b0, 3'd0, 18'h3FFFF, 1'b1, 3'd0, 1'b0);
            step();
            drive_idle();
            chk($sformatf("busy_sweep_%0d", k), 32'(busy), 32'd1);
        end
        step();
        chk("busy_sweep_end", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) rd(3'(i), 18'h0);

        // Reset mid-sweep aborts; inputs during reset have no effect.
        for (int i = 0; i < 8; i++) wr(3'(i), 18'h2AAAA);
        rd(3'd7, 18'h2AAAA);
        op(1'b1, 3'd0, 18'h0, 1'b1, 3'd0, 1'b1);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("abort_q",    32'(q),    32'd0);
        chk("abort_qv",   32'(qv),   32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        drive(1'b0, 3'd3, 18'h0, 1'b0, 3'd4, 1'b1);
        step(); step();
        chk("rst_hold_busy", 32'(busy), 32'd0);
        chk("rst_hold_qv",   32'(qv),   32'd0);
        drive_idle();
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) rd(3'(i), (i < 3) ? 18'h0 : 18'h2AAAA);

        step(); step(); step();
        chk("exp8_drained", 32'(exp8.size()), 32'd0);
        chk("exp6_drained", 32'(exp6.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
